// File: rtl/data_island_packet_serializer_if.sv
// rtl/data_island_packet_serializer_if.sv - packet-side bundle between picker and serializer
//
// Purpose: groups the per-packet inputs (enable, header, subpackets) and the
// serialized outputs (TERC4 payload bits, bit position, end marker).
//   data_island_period : high while packet cycles are transmitted
//   header[23:0]       : HB0 = [7:0], HB1 = [15:8], HB2 = [23:16]
//   sub[3:0][55:0]     : subpackets 0..3, PB0 = [7:0] .. PB6 = [55:48]
//   packet_data[8:0]   : {ch2[3:0], ch1[3:0], ch0_bit2}
//   counter[4:0]       : bit position within the packet, 0..31
//   packet_end         : high in the last cycle of a packet
// master drives the packet (picker side), slave is the serializer.
interface data_island_packet_serializer_if;
  logic             data_island_period;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic [8:0]       packet_data;
  logic [4:0]       counter;
  logic             packet_end;

  modport master (
    output data_island_period, header, sub,
    input  packet_data, counter, packet_end
  );

  modport slave (
    input  data_island_period, header, sub,
    output packet_data, counter, packet_end
  );
endinterface

// File: rtl/data_island_packet_serializer.sv
// rtl/data_island_packet_serializer.sv - HDMI data-island packet to 32-cycle TERC4 bit stream
//
// Purpose: walks a 5-bit position counter across one packet, emits header and
// subpacket bits in the same cycle as their position, and accumulates the BCH
// ECC bytes serially so they can be appended in the tail cycles.
//   clk_pixel : pixel clock, all state on rising edge
//   reset     : asynchronous active-high reset
//   bus       : slave side of data_island_packet_serializer_if
//               (data_island_period, header, sub in; packet_data, counter,
//               packet_end out)
module data_island_packet_serializer (
  input  logic                           clk_pixel,
  input  logic                           reset,
  data_island_packet_serializer_if.slave bus
);

  logic [4:0]      cnt;
  logic [7:0]      ecc_h;
  logic [3:0][7:0] ecc_s;
  logic [3:0]      ch1;
  logic [3:0]      ch2;
  logic            ch0_bit2;

  // One LSB-first step of the BCH(64,56)/(32,24) LFSR, generator x^8+x^7+x^6+1.
  function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
    return {1'b0, e[7:1]} ^ ({8{e[0] ^ b}} & 8'h83);
  endfunction

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      cnt   <= 5'd0;
      ecc_h <= 8'h00;
      ecc_s <= '0;
    end else if (!bus.data_island_period) begin
      cnt   <= 5'd0;
      ecc_h <= 8'h00;
      ecc_s <= '0;
    end else begin
      // 5-bit counter wraps 31 -> 0 on its own for back-to-back packets.
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        ecc_h <= 8'h00;
        ecc_s <= '0;
      end else begin
        // Registers hold outside their data windows so the tail cycles can
        // read out a stable ECC byte.
        if (cnt <= 5'd23)
          ecc_h <= bch_step(ecc_h, bus.header[cnt]);
        if (cnt <= 5'd27) begin
          for (int n = 0; n < 4; n++)
            ecc_s[n] <= bch_step(bch_step(ecc_s[n], bus.sub[n][{cnt, 1'b0}]),
                                 bus.sub[n][{cnt, 1'b1}]);
        end
      end
    end
  end

  // Tail cycles: positions 24..31 map to ecc_h bit cnt[2:0]; positions 28..31
  // map to ecc_s bit pair cnt[1:0].
  always_comb begin
    ch1 = 4'd0;
    ch2 = 4'd0;
    if (cnt < 5'd24)
      ch0_bit2 = bus.header[cnt];
    else
      ch0_bit2 = ecc_h[cnt[2:0]];
    for (int n = 0; n < 4; n++) begin
      if (cnt < 5'd28) begin
        ch1[n] = bus.sub[n][{cnt, 1'b0}];
        ch2[n] = bus.sub[n][{cnt, 1'b1}];
      end else begin
        ch1[n] = ecc_s[n][{cnt[1:0], 1'b0}];
        ch2[n] = ecc_s[n][{cnt[1:0], 1'b1}];
      end
    end
  end

  assign bus.packet_data = {ch2, ch1, ch0_bit2};
  assign bus.counter     = cnt;
  assign bus.packet_end  = bus.data_island_period && (cnt == 5'd31);

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// tb/tb_data_island_packet_serializer.sv - self-checking bench for data_island_packet_serializer
module tb_data_island_packet_serializer;

  logic clk_pixel = 1'b0;
  logic reset     = 1'b1;
  int   checks    = 0;
  int   errors    = 0;
  int   pos       = 0;
  logic [8:0] obs_pd [32];
  logic       obs_pe [32];

  data_island_packet_serializer_if dut_if ();

  data_island_packet_serializer dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .bus       (dut_if.slave)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // ECC of a whole bit string, consumed LSB first.
  function automatic logic [7:0] ecc_of(input logic [63:0] bits, input int len);
    logic [7:0] e = 8'h00;
    for (int i = 0; i < len; i++)
      e = {1'b0, e[7:1]} ^ ({8{e[0] ^ bits[i]}} & 8'h83);
    return e;
  endfunction

  // Expected packet_data at position p: each lane is data followed by its ECC.
  function automatic logic [8:0] model_pd(input logic [23:0] h,
                                          input logic [3:0][55:0] s,
                                          input int p);
    logic [31:0] hs;
    logic [63:0] ss;
    logic [3:0]  c1, c2;
    hs = {ecc_of({40'd0, h}, 24), h};
    for (int n = 0; n < 4; n++) begin
      ss = {ecc_of({8'd0, s[n]}, 56), s[n]};
      c1[n] = ss[2*p];
      c2[n] = ss[2*p+1];
    end
    return {c2, c1, hs[p]};
  endfunction

  // Model position: restarts on reset or idle, wraps after 32.
  always @(posedge clk_pixel or posedge reset) begin
    if (reset)                          pos = 0;
    else if (!dut_if.data_island_period) pos = 0;
    else                                pos = (pos + 1) % 32;
  end

  always @(negedge clk_pixel) begin
    chk("counter", {27'd0, dut_if.counter}, pos);
    chk("packet_end", {31'd0, dut_if.packet_end},
        {31'd0, dut_if.data_island_period && !reset && pos == 31});
    chk("packet_data", {23'd0, dut_if.packet_data},
        {23'd0, model_pd(dut_if.header, dut_if.sub, pos)});
    obs_pd[pos] = dut_if.packet_data;
    obs_pe[pos] = dut_if.packet_end;
  end

  task automatic step_cycles(input int n);
    repeat (n) begin
      @(posedge clk_pixel);
      #1;
    end
  endtask

  task automatic set_inputs(input logic [23:0] h, input logic [3:0][55:0] s);
    dut_if.header = h;
    dut_if.sub    = s;
  endtask

  task automatic random_inputs();
    logic [3:0][55:0] s;
    for (int n = 0; n < 4; n++)
      s[n] = {$urandom, $urandom};
    set_inputs($urandom, s);
  endtask

  task automatic run_packet();
    dut_if.data_island_period = 1'b1;
    step_cycles(32);
  endtask

  logic [7:0] v8;
  logic [3:0] v4;
  logic [8:0] acc;
  int pe_count;
  logic [3:0][55:0] zs;

  initial begin
    zs = '0;
    dut_if.data_island_period = 1'b0;
    set_inputs(24'd0, zs);
    step_cycles(2);
    chk("reset_counter", {27'd0, dut_if.counter}, 32'd0);
    chk("reset_packet_end", {31'd0, dut_if.packet_end}, 32'd0);
    chk("reset_packet_data", {23'd0, dut_if.packet_data}, 32'd0);
    reset = 1'b0;
    step_cycles(2);

    // Model pins.
    chk("model_ecc_h", {24'd0, ecc_of(64'h800000, 24)}, 32'h83);
    chk("model_ecc_s54", {24'd0, ecc_of(64'h0040_0000_0000_0000, 56)}, 32'hC2);

    // All-zero packet.
    run_packet();
    acc = '0;
    pe_count = 0;
    for (int i = 0; i < 32; i++) begin
      acc |= obs_pd[i];
      pe_count += int'(obs_pe[i]);
    end
    chk("zero_pd_or", {23'd0, acc}, 32'd0);
    chk("zero_pe_count", pe_count, 32'd1);
    chk("zero_pe_at_31", {31'd0, obs_pe[31]}, 32'd1);

    // Header MSB only.
    set_inputs(24'h800000, zs);
    run_packet();
    v8 = '0;
    for (int i = 0; i < 23; i++) v8[0] = v8[0] | obs_pd[i][0];
    chk("hdr_low_bits", {31'd0, v8[0]}, 32'd0);
    chk("hdr_bit23", {31'd0, obs_pd[23][0]}, 32'd1);
    for (int j = 0; j < 8; j++) v8[j] = obs_pd[24+j][0];
    chk("hdr_ecc_bits", {24'd0, v8}, 32'h83);

    // Subpacket 0 top bit.
    zs[0] = 56'h80_0000_0000_0000;
    set_inputs(24'd0, zs);
    run_packet();
    for (int j = 0; j < 4; j++) v4[j] = obs_pd[28+j][1];
    chk("sub0_ch1_ecc", {28'd0, v4}, 32'b0001);
    for (int j = 0; j < 4; j++) v4[j] = obs_pd[28+j][5];
    chk("sub0_ch2_ecc", {28'd0, v4}, 32'b1001);
    chk("sub0_other_lanes", {23'd0, obs_pd[30] & 9'b1_1101_1101}, 32'd0);

    // Subpacket 2 bit 54: ecc 8'hC2.
    zs[0] = '0;
    zs[2] = 56'h40_0000_0000_0000;
    set_inputs(24'd0, zs);
    run_packet();
    for (int j = 0; j < 4; j++) v4[j] = obs_pd[28+j][3];
    chk("sub2_ch1_ecc", {28'd0, v4}, 32'b1000);
    for (int j = 0; j < 4; j++) v4[j] = obs_pd[28+j][7];
    chk("sub2_ch2_ecc", {28'd0, v4}, 32'b1001);

    // Back-to-back random packets.
    for (int k = 0; k < 6; k++) begin
      random_inputs();
      run_packet();
    end

    // Deassert mid-packet at position 12, then a clean packet.
    random_inputs();
    dut_if.data_island_period = 1'b1;
    step_cycles(12);
    dut_if.data_island_period = 1'b0;
    step_cycles(1);
    chk("abort_counter", {27'd0, dut_if.counter}, 32'd0);
    run_packet();

    // Reset pulse at position 20 with enable held high.
    random_inputs();
    dut_if.data_island_period = 1'b1;
    step_cycles(20);
    reset = 1'b1;
    #1;
    chk("reset_mid_counter", {27'd0, dut_if.counter}, 32'd0);
    step_cycles(1);
    reset = 1'b0;
    step_cycles(32);
    random_inputs();
    run_packet();

    dut_if.data_island_period = 1'b0;
    step_cycles(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
